// File: rtl/uart_frame_parser.sv
// Extracts HEAD0 HEAD1 LEN PAYLOAD[LEN] CHK frames from a received byte stream,
// buffers the payload and releases it on a ready/valid stream only when the checksum matches.
module uart_frame_parser #(
  parameter int DATA_WIDTH     = 8,
  parameter logic [7:0] HEAD0  = 8'h55,
  parameter logic [7:0] HEAD1  = 8'hAA,
  parameter int MAX_LEN        = 16,
  parameter int TIMEOUT_CYCLES = 20
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_rx_data,
  input  logic                  i_rx_valid,
  output logic [DATA_WIDTH-1:0] o_pl_data,
  output logic                  o_pl_valid,
  output logic                  o_pl_last,
  input  logic                  i_pl_ready,
  output logic                  o_frame_done,
  output logic                  o_frame_ok,
  output logic [1:0]            o_err_code,
  output logic                  o_overrun
);

  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [2:0] ST_HUNT0   = 3'd0;
  localparam logic [2:0] ST_HUNT1   = 3'd1;
  localparam logic [2:0] ST_LEN     = 3'd2;
  localparam logic [2:0] ST_PAYLOAD = 3'd3;
  localparam logic [2:0] ST_CHK     = 3'd4;
  localparam logic [2:0] ST_DRAIN   = 3'd5;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_CHK     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  logic [2:0]            state_reg;
  logic [7:0]            len_reg;
  logic [7:0]            wr_cnt_reg;
  logic [7:0]            rd_ptr_reg;
  logic [DATA_WIDTH-1:0] sum_reg;
  logic [TW-1:0]         idle_reg;
  logic                  done_reg;
  logic                  ok_reg;
  logic [1:0]            err_reg;
  logic                  overrun_reg;
  logic [DATA_WIDTH-1:0] mem [MAX_LEN];

  logic in_frame;
  logic idle_expired;
  logic len_good;

  assign in_frame     = (state_reg == ST_HUNT1) || (state_reg == ST_LEN) ||
                        (state_reg == ST_PAYLOAD) || (state_reg == ST_CHK);
  assign idle_expired = (idle_reg == TW'(TIMEOUT_CYCLES - 1));
  assign len_good     = (i_rx_data != '0) && (i_rx_data <= DATA_WIDTH'(MAX_LEN));

  // Payload storage has no reset: contents are only ever read after a full frame rewrote them.
  always_ff @(posedge i_clk) begin
    if (state_reg == ST_PAYLOAD && i_rx_valid)
      mem[wr_cnt_reg[AW-1:0]] <= i_rx_data;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_reg   <= ST_HUNT0;
      len_reg     <= '0;
      wr_cnt_reg  <= '0;
      rd_ptr_reg  <= '0;
      sum_reg     <= '0;
      idle_reg    <= '0;
      done_reg    <= 1'b0;
      ok_reg      <= 1'b0;
      err_reg     <= ERR_OK;
      overrun_reg <= 1'b0;
    end else begin
      done_reg    <= 1'b0;
      overrun_reg <= 1'b0;
      if (in_frame && !i_rx_valid) begin
        // A byte in the expiring cycle takes the other branch, so it always wins over the timeout.
        if (idle_expired) begin
          state_reg <= ST_HUNT0;
          idle_reg  <= '0;
          done_reg  <= 1'b1;
          ok_reg    <= 1'b0;
          err_reg   <= ERR_TIMEOUT;
        end else begin
          idle_reg <= idle_reg + 1'b1;
        end
      end else begin
        if (i_rx_valid)
          idle_reg <= '0;
        case (state_reg)
          ST_HUNT0: begin
            if (i_rx_valid && i_rx_data == HEAD0)
              state_reg <= ST_HUNT1;
          end
          ST_HUNT1: begin
            if (i_rx_data == HEAD1)
              state_reg <= ST_LEN;
            else if (i_rx_data != HEAD0)
              state_reg <= ST_HUNT0;
          end
          ST_LEN: begin
            if (len_good) begin
              len_reg    <= i_rx_data;
              sum_reg    <= i_rx_data;
              wr_cnt_reg <= '0;
              state_reg  <= ST_PAYLOAD;
            end else begin
              state_reg <= ST_HUNT0;
              done_reg  <= 1'b1;
              ok_reg    <= 1'b0;
              err_reg   <= ERR_LEN;
            end
          end
          ST_PAYLOAD: begin
            sum_reg    <= sum_reg + i_rx_data;
            wr_cnt_reg <= wr_cnt_reg + 8'd1;
            if (wr_cnt_reg == len_reg - 8'd1)
              state_reg <= ST_CHK;
          end
          ST_CHK: begin
            done_reg <= 1'b1;
            if (i_rx_data == sum_reg) begin
              state_reg  <= ST_DRAIN;
              rd_ptr_reg <= '0;
              ok_reg     <= 1'b1;
              err_reg    <= ERR_OK;
            end else begin
              state_reg <= ST_HUNT0;
              ok_reg    <= 1'b0;
              err_reg   <= ERR_CHK;
            end
          end
          ST_DRAIN: begin
            if (i_rx_valid)
              overrun_reg <= 1'b1;
            if (i_pl_ready) begin
              rd_ptr_reg <= rd_ptr_reg + 8'd1;
              if (rd_ptr_reg == len_reg - 8'd1)
                state_reg <= ST_HUNT0;
            end
          end
          default: state_reg <= ST_HUNT0;
        endcase
      end
    end
  end

  assign o_pl_valid   = (state_reg == ST_DRAIN);
  assign o_pl_last    = o_pl_valid && (rd_ptr_reg == len_reg - 8'd1);
  assign o_pl_data    = o_pl_valid ? mem[rd_ptr_reg[AW-1:0]] : '0;
  assign o_frame_done = done_reg;
  assign o_frame_ok   = ok_reg;
  assign o_err_code   = err_reg;
  assign o_overrun    = overrun_reg;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed checks for uart_frame_parser: good/bad frames, resync, timeout, stalled drain, reset abort.
module tb_uart_frame_parser;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b0;
  logic [7:0] i_rx_data = '0;
  logic       i_rx_valid = 1'b0;
  logic [7:0] o_pl_data;
  logic       o_pl_valid;
  logic       o_pl_last;
  logic       i_pl_ready = 1'b1;
  logic       o_frame_done;
  logic       o_frame_ok;
  logic [1:0] o_err_code;
  logic       o_overrun;

  int pass_cnt = 0;
  int total_cnt = 0;
  int idle_cycles;

  always #5 i_clk = ~i_clk;

  uart_frame_parser dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_rx_data   (i_rx_data),
    .i_rx_valid  (i_rx_valid),
    .o_pl_data   (o_pl_data),
    .o_pl_valid  (o_pl_valid),
    .o_pl_last   (o_pl_last),
    .i_pl_ready  (i_pl_ready),
    .o_frame_done(o_frame_done),
    .o_frame_ok  (o_frame_ok),
    .o_err_code  (o_err_code),
    .o_overrun   (o_overrun)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total_cnt++;
    assert (observed === expected) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte was consumed.
  task automatic send_byte(input logic [7:0] b);
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    @(negedge i_clk);
    i_rx_valid = 1'b0;
  endtask

  task automatic check_status(input string tag, input logic done, input logic ok, input logic [1:0] err);
    check({tag, "_done"}, 32'(o_frame_done), 32'(done));
    check({tag, "_ok"},   32'(o_frame_ok),   32'(ok));
    check({tag, "_err"},  32'(o_err_code),   32'(err));
  endtask

  task automatic check_pl(input string tag, input logic valid, input logic [7:0] data, input logic last);
    check({tag, "_valid"}, 32'(o_pl_valid), 32'(valid));
    check({tag, "_data"},  32'(o_pl_data),  32'(data));
    check({tag, "_last"},  32'(o_pl_last),  32'(last));
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge i_clk);
    check_status("rst", 1'b0, 1'b0, 2'd0);
    check_pl("rst", 1'b0, 8'h00, 1'b0);
    check("rst_overrun", 32'(o_overrun), 32'd0);
    i_rst = 1'b1;
    @(negedge i_clk);

    // Good frame 55 AA 03 11 22 33 69, ready held high
    send_byte(8'h55); send_byte(8'hAA); send_byte(8'h03);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    send_byte(8'h69);
    check_status("good", 1'b1, 1'b1, 2'd0);
    check_pl("good_b0", 1'b1, 8'h11, 1'b0);
    @(negedge i_clk);
    check("good_done_pulse", 32'(o_frame_done), 32'd0);
    check_pl("good_b1", 1'b1, 8'h22, 1'b0);
    @(negedge i_clk);
    check_pl("good_b2", 1'b1, 8'h33, 1'b1);
    @(negedge i_clk);
    check_pl("good_end", 1'b0, 8'h00, 1'b0);
    check_status("good_hold", 1'b0, 1'b1, 2'd0);

    // Bad checksum
    send_byte(8'h55); send_byte(8'hAA); send_byte(8'h03);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    send_byte(8'h68);
    check_status("badchk", 1'b1, 1'b0, 2'd2);
    check("badchk_valid", 32'(o_pl_valid), 32'd0);
    @(negedge i_clk);
    check("badchk_valid2", 32'(o_pl_valid), 32'd0);
    check_status("badchk_hold", 1'b0, 1'b0, 2'd2);

    // Bad lengths: zero and MAX_LEN+1
    send_byte(8'h55); send_byte(8'hAA); send_byte(8'h00);
    check_status("len0", 1'b1, 1'b0, 2'd1);
    @(negedge i_clk);
    send_byte(8'h55); send_byte(8'hAA); send_byte(8'h11);
    check_status("len17", 1'b1, 1'b0, 2'd1);
    @(negedge i_clk);

    // Header resync: second 55 keeps HUNT1
    send_byte(8'h55); send_byte(8'h55); send_byte(8'hAA);
    send_byte(8'h01); send_byte(8'h7E); send_byte(8'h7F);
    check_status("resync", 1'b1, 1'b1, 2'd0);
    check_pl("resync_b0", 1'b1, 8'h7E, 1'b1);
    @(negedge i_clk);
    check("resync_end", 32'(o_pl_valid), 32'd0);

    // Timeout inside payload
    send_byte(8'h55); send_byte(8'hAA); send_byte(8'h02); send_byte(8'h10);
    idle_cycles = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge i_clk);
      if (o_frame_done) begin
        idle_cycles = i;
        break;
      end
    end
    check("timeout_cycles", 32'(idle_cycles), 32'd20);
    check_status("timeout", 1'b1, 1'b0, 2'd3);
    @(negedge i_clk);
    send_byte(8'h55); send_byte(8'hAA); send_byte(8'h02);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h05);
    check_status("post_to", 1'b1, 1'b1, 2'd0);
    check_pl("post_to_b0", 1'b1, 8'h01, 1'b0);
    @(negedge i_clk);
    check_pl("post_to_b1", 1'b1, 8'h02, 1'b1);
    @(negedge i_clk);

    // Stalled drain with an overrun byte; checksum 04+A1+B2+C3+D4 = EE
    send_byte(8'h55); send_byte(8'hAA); send_byte(8'h04);
    send_byte(8'hA1); send_byte(8'hB2); send_byte(8'hC3); send_byte(8'hD4);
    i_pl_ready = 1'b0;
    send_byte(8'hEE);
    check_status("stall", 1'b1, 1'b1, 2'd0);
    check_pl("stall_b0", 1'b1, 8'hA1, 1'b0);
    @(negedge i_clk);
    check_pl("stall_b0_hold", 1'b1, 8'hA1, 1'b0);
    send_byte(8'h55);
    check("overrun_pulse", 32'(o_overrun), 32'd1);
    check_pl("stall_b0_hold2", 1'b1, 8'hA1, 1'b0);
    i_pl_ready = 1'b1;
    @(negedge i_clk);
    check("overrun_clear", 32'(o_overrun), 32'd0);
    check_pl("stall_b1", 1'b1, 8'hB2, 1'b0);
    i_pl_ready = 1'b0;
    @(negedge i_clk);
    check_pl("stall_b1_hold", 1'b1, 8'hB2, 1'b0);
    i_pl_ready = 1'b1;
    @(negedge i_clk);
    check_pl("stall_b2", 1'b1, 8'hC3, 1'b0);
    i_pl_ready = 1'b0;
    @(negedge i_clk);
    check_pl("stall_b2_hold", 1'b1, 8'hC3, 1'b0);
    i_pl_ready = 1'b1;
    @(negedge i_clk);
    check_pl("stall_b3", 1'b1, 8'hD4, 1'b1);
    i_pl_ready = 1'b0;
    @(negedge i_clk);
    check_pl("stall_b3_hold", 1'b1, 8'hD4, 1'b1);
    i_pl_ready = 1'b1;
    @(negedge i_clk);
    check("stall_end", 32'(o_pl_valid), 32'd0);
    check("overrun_once", 32'(o_overrun), 32'd0);

    // Async reset mid-payload: held ok=1 must drop without a clock edge
    send_byte(8'h55); send_byte(8'hAA); send_byte(8'h03); send_byte(8'h11);
    check("pre_rst_ok", 32'(o_frame_ok), 32'd1);
    #2;
    i_rst = 1'b0;
    #1;
    check_status("async_rst", 1'b0, 1'b0, 2'd0);
    check_pl("async_rst", 1'b0, 8'h00, 1'b0);
    @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    send_byte(8'h22); send_byte(8'h33); send_byte(8'h69);
    check("rst_discard_done", 32'(o_frame_done), 32'd0);
    send_byte(8'h55); send_byte(8'hAA); send_byte(8'h01);
    send_byte(8'h42); send_byte(8'h43);
    check_status("post_rst", 1'b1, 1'b1, 2'd0);
    check_pl("post_rst_b0", 1'b1, 8'h42, 1'b1);
    @(negedge i_clk);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
